// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch/sequencing front end for a small processor. Reads one
// 16-bit instruction word from program memory, presents its decoded fields
// to the Control_Unit for one DECODE cycle, waits in EXEC until the
// Control_Unit finishes, then selects the next pc (halt, return, branch or
// sequential).
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   mem_addr, mem_rd       program memory word address and read request
//   mem_rdata, mem_ready   instruction word and its valid strobe
//   opcode, rsel, imm16,
//   target                 combinational decodes of the instruction register
//   pc_out                 current pc (return address during EXEC)
//   instr_valid            one-cycle pulse in DECODE
//   exec_done, bra,
//   pc_load, pc_load_val,
//   hlt                    Control_Unit handshake, only honoured in EXEC
//   halted                 high while halted
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [5:0]  opcode,
  output logic        rsel,
  output logic [15:0] imm16,
  output logic [9:0]  target,
  output logic [9:0]  pc_out,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        bra,
  input  logic        pc_load,
  input  logic [9:0]  pc_load_val,
  input  logic        hlt,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [9:0]  pc, pc_next;
  logic [15:0] ir, ir_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= 10'd0;
      ir    <= 16'h0000;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  // The pc is bumped in DECODE so that during EXEC it already points at the
  // next sequential instruction; EXEC then only overrides it for RET/branch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (mem_ready) begin
          ir_next    = mem_rdata;
          state_next = DECODE;
        end
      end
      DECODE: begin
        pc_next    = pc + 10'd1;
        state_next = EXEC;
      end
      EXEC: begin
        if (exec_done) begin
          if (hlt) begin
            state_next = HALT;
          end else begin
            state_next = FETCH;
            if (pc_load)
              pc_next = pc_load_val;
            else if (bra)
              pc_next = ir[9:0];
          end
        end
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  assign mem_rd      = (state == FETCH);
  assign mem_addr    = pc;
  assign instr_valid = (state == DECODE);
  assign halted      = (state == HALT);
  assign pc_out      = pc;

  assign opcode = ir[15:10];
  assign rsel   = ir[9];
  assign imm16  = {{7{ir[8]}}, ir[8:0]};
  assign target = ir[9:0];

endmodule
